// File: rtl/efx_mixed_width_sdpram.sv
// Single-clock simple dual-port RAM with independent power-of-2 write/read widths.
// Define SDPRAM_COLLISION_FLAG_EN to add the read/write overlap flag output.
module efx_mixed_width_sdpram #(
    parameter int    WR_DATA_WIDTH = 8,
    parameter int    RD_DATA_WIDTH = 16,
    parameter int    WR_ADDR_WIDTH = 4,
    parameter int    BYTE_WIDTH    = 8,
    parameter string WRITE_MODE    = "READ_FIRST",
    parameter int    OUTPUT_REG    = 0,
    localparam int   BYTEEN_WIDTH  = (WR_DATA_WIDTH / BYTE_WIDTH > 1) ? WR_DATA_WIDTH / BYTE_WIDTH : 1,
    localparam int   RD_ADDR_WIDTH = $clog2((WR_DATA_WIDTH * (2 ** WR_ADDR_WIDTH)) / RD_DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     waddren,
    input  logic [WR_ADDR_WIDTH-1:0] waddr,
    input  logic [WR_DATA_WIDTH-1:0] wdata,
    input  logic [BYTEEN_WIDTH-1:0]  byteen,
    input  logic                     re,
    input  logic                     raddren,
    input  logic [RD_ADDR_WIDTH-1:0] raddr,
    output logic [RD_DATA_WIDTH-1:0] rdata,
    output logic                     rvalid
`ifdef SDPRAM_COLLISION_FLAG_EN
    ,
    output logic                     collision
`endif
);

    // Storage is kept in units of the narrower port; the wide port spans RATIO units.
    localparam int NARROW_W    = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int WR_LANES    = WR_DATA_WIDTH / NARROW_W;
    localparam int RD_LANES    = RD_DATA_WIDTH / NARROW_W;
    localparam int WL_LOG      = $clog2(WR_LANES);
    localparam int RL_LOG      = $clog2(RD_LANES);
    localparam int UNIT_AW     = WR_ADDR_WIDTH + WL_LOG;
    localparam int UNITS       = 2 ** UNIT_AW;
    localparam bit WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");

    logic [NARROW_W-1:0]      mem [0:UNITS-1];

    logic [WR_ADDR_WIDTH-1:0] wlatch_reg;
    logic [RD_ADDR_WIDTH-1:0] rlatch_reg;
    logic [WR_ADDR_WIDTH-1:0] eff_waddr;
    logic [RD_ADDR_WIDTH-1:0] eff_raddr;
    logic [WR_DATA_WIDTH-1:0] wmask;
    logic [UNIT_AW-1:0]       wunit      [WR_LANES];
    logic [NARROW_W-1:0]      wlane_data [WR_LANES];
    logic [NARROW_W-1:0]      wlane_mask [WR_LANES];
    logic [RD_DATA_WIDTH-1:0] rd_word;
    logic [RD_DATA_WIDTH-1:0] rd_stage_reg;
    logic                     rvalid_stage_reg;
`ifdef SDPRAM_COLLISION_FLAG_EN
    logic [RD_LANES-1:0]      lane_coll;
    logic                     coll_stage_reg;
`endif

    assign eff_waddr = waddren ? waddr : wlatch_reg;
    assign eff_raddr = raddren ? raddr : rlatch_reg;

    genvar gi;
    generate
        // Per-bit write enable, already qualified by the write strobe.
        for (gi = 0; gi < WR_DATA_WIDTH; gi++) begin : g_wmask
            assign wmask[gi] = we & byteen[gi / BYTE_WIDTH];
        end

        for (gi = 0; gi < WR_LANES; gi++) begin : g_wr_lane
            assign wunit[gi]      = (UNIT_AW'(eff_waddr) << WL_LOG) | UNIT_AW'(gi);
            assign wlane_data[gi] = wdata[gi*NARROW_W +: NARROW_W];
            assign wlane_mask[gi] = wmask[gi*NARROW_W +: NARROW_W];
        end

        // Each read lane checks whether the same-edge write lands on its unit.
        for (gi = 0; gi < RD_LANES; gi++) begin : g_rd_lane
            logic [UNIT_AW-1:0]  runit;
            logic [UNIT_AW-1:0]  wsel;
            logic                word_hit;
            logic [NARROW_W-1:0] old_bits;
            logic [NARROW_W-1:0] new_bits;
            logic [NARROW_W-1:0] ov_mask;

            assign runit    = (UNIT_AW'(eff_raddr) << RL_LOG) | UNIT_AW'(gi);
            assign wsel     = runit & UNIT_AW'(WR_LANES - 1);
            assign word_hit = (WR_ADDR_WIDTH'(runit >> WL_LOG) == eff_waddr);
            assign old_bits = mem[runit];
            assign new_bits = NARROW_W'(wdata >> (32'(wsel) * NARROW_W));
            assign ov_mask  = word_hit ? NARROW_W'(wmask >> (32'(wsel) * NARROW_W)) : '0;
            assign rd_word[gi*NARROW_W +: NARROW_W] =
                WRITE_FIRST ? ((old_bits & ~ov_mask) | (new_bits & ov_mask)) : old_bits;
`ifdef SDPRAM_COLLISION_FLAG_EN
            assign lane_coll[gi] = |ov_mask;
`endif
        end
    endgenerate

    // Memory contents survive reset; only the write is suppressed while it is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < WR_LANES; l++) begin
                for (int b = 0; b < NARROW_W; b++) begin
                    if (wlane_mask[l][b]) begin
                        mem[wunit[l]][b] <= wlane_data[l][b];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wlatch_reg       <= '0;
            rlatch_reg       <= '0;
            rd_stage_reg     <= '0;
            rvalid_stage_reg <= 1'b0;
        end else begin
            if (waddren) begin
                wlatch_reg <= waddr;
            end
            if (raddren) begin
                rlatch_reg <= raddr;
            end
            if (re) begin
                rd_stage_reg <= rd_word;
            end
            rvalid_stage_reg <= re;
        end
    end

`ifdef SDPRAM_COLLISION_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_stage_reg <= 1'b0;
        end else begin
            coll_stage_reg <= re & (|lane_coll);
        end
    end
`endif

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [RD_DATA_WIDTH-1:0] rdata_reg;
            logic                     rvalid_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rdata_reg  <= rd_stage_reg;
                    rvalid_reg <= rvalid_stage_reg;
                end
            end
            assign rdata  = rdata_reg;
            assign rvalid = rvalid_reg;
`ifdef SDPRAM_COLLISION_FLAG_EN
            logic collision_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    collision_reg <= 1'b0;
                end else begin
                    collision_reg <= coll_stage_reg;
                end
            end
            assign collision = collision_reg;
`endif
        end else begin : g_no_out_reg
            assign rdata  = rd_stage_reg;
            assign rvalid = rvalid_stage_reg;
`ifdef SDPRAM_COLLISION_FLAG_EN
            assign collision = coll_stage_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_efx_mixed_width_sdpram.sv
// Bench for efx_mixed_width_sdpram: 8->16 READ_FIRST and WRITE_FIRST/registered instances
// share a vector table and scoreboard; 16->8 and 32/32 instances get short directed sequences.
`timescale 1ns/1ps
module tb_efx_mixed_width_sdpram;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // Shared stimulus for u_a (READ_FIRST, latency 1) and u_b (WRITE_FIRST, latency 2)
    logic        we = 0, waddren = 0, re = 0, raddren = 0, byteen = 0;
    logic [3:0]  waddr = 0;
    logic [7:0]  wdata = 0;
    logic [2:0]  raddr = 0;
    logic [15:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;

    logic        we_c = 0, waddren_c = 0, re_c = 0, raddren_c = 0;
    logic [2:0]  waddr_c = 0;
    logic [15:0] wdata_c = 0;
    logic [1:0]  byteen_c = 0;
    logic [3:0]  raddr_c = 0;
    logic [7:0]  rdata_c;
    logic        rvalid_c;

    logic        we_d = 0, waddren_d = 0, re_d = 0, raddren_d = 0;
    logic [1:0]  waddr_d = 0, raddr_d = 0;
    logic [31:0] wdata_d = 0, rdata_d;
    logic [3:0]  byteen_d = 0;
    logic        rvalid_d;
`ifdef SDPRAM_COLLISION_FLAG_EN
    logic        coll_a, coll_b, coll_c, coll_d;
`endif

    efx_mixed_width_sdpram #(.WRITE_MODE("READ_FIRST"), .OUTPUT_REG(0)) u_a (
        .clk(clk), .reset(reset), .we(we), .waddren(waddren), .waddr(waddr), .wdata(wdata),
        .byteen(byteen), .re(re), .raddren(raddren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
`ifdef SDPRAM_COLLISION_FLAG_EN
        , .collision(coll_a)
`endif
    );

    efx_mixed_width_sdpram #(.WRITE_MODE("WRITE_FIRST"), .OUTPUT_REG(1)) u_b (
        .clk(clk), .reset(reset), .we(we), .waddren(waddren), .waddr(waddr), .wdata(wdata),
        .byteen(byteen), .re(re), .raddren(raddren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
`ifdef SDPRAM_COLLISION_FLAG_EN
        , .collision(coll_b)
`endif
    );

    efx_mixed_width_sdpram #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(8), .WR_ADDR_WIDTH(3)) u_c (
        .clk(clk), .reset(reset), .we(we_c), .waddren(waddren_c), .waddr(waddr_c), .wdata(wdata_c),
        .byteen(byteen_c), .re(re_c), .raddren(raddren_c), .raddr(raddr_c), .rdata(rdata_c), .rvalid(rvalid_c)
`ifdef SDPRAM_COLLISION_FLAG_EN
        , .collision(coll_c)
`endif
    );

    efx_mixed_width_sdpram #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(32), .WR_ADDR_WIDTH(2)) u_d (
        .clk(clk), .reset(reset), .we(we_d), .waddren(waddren_d), .waddr(waddr_d), .wdata(wdata_d),
        .byteen(byteen_d), .re(re_d), .raddren(raddren_d), .raddr(raddr_d), .rdata(rdata_d), .rvalid(rvalid_d)
`ifdef SDPRAM_COLLISION_FLAG_EN
        , .collision(coll_d)
`endif
    );

    typedef struct {
        logic        we, wae;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic        be, re, rae;
        logic [2:0]  ra;
        logic [15:0] exp_rf, exp_wf;
        logic        exp_coll;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        coll;
        int          due;
    } exp_t;

    vec_t vecs[$];
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    function automatic vec_t mk(input logic we_i, input logic wae_i, input logic [3:0] wa_i,
                                input logic [7:0] wd_i, input logic be_i, input logic re_i,
                                input logic rae_i, input logic [2:0] ra_i, input logic [15:0] rf_i,
                                input logic [15:0] wf_i, input logic coll_i);
        vec_t v;
        v.we = we_i; v.wae = wae_i; v.wa = wa_i; v.wd = wd_i; v.be = be_i;
        v.re = re_i; v.rae = rae_i; v.ra = ra_i;
        v.exp_rf = rf_i; v.exp_wf = wf_i; v.exp_coll = coll_i;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        we = v.we; waddren = v.wae; waddr = v.wa; wdata = v.wd; byteen = v.be;
        re = v.re; raddren = v.rae; raddr = v.ra;
        @(posedge clk); #1;
        if (v.re) begin
            e.coll = v.exp_coll;
            e.data = v.exp_rf; e.due = cyc;     q_a.push_back(e);
            e.data = v.exp_wf; e.due = cyc + 1; q_b.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        we = 0; re = 0; waddren = 0; raddren = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid_a) begin
                if (q_a.size() == 0) begin
                    check("a_spurious_rvalid", 64'(rvalid_a), 64'(0));
                end else begin
                    ea = q_a.pop_front();
                    check("a_rdata", 64'(rdata_a), 64'(ea.data));
                    check("a_latency_cycle", 64'(cyc), 64'(ea.due));
`ifdef SDPRAM_COLLISION_FLAG_EN
                    check("a_collision", 64'(coll_a), 64'(ea.coll));
`endif
                end
            end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
                check("a_missing_rvalid", 64'(rvalid_a), 64'(1));
                void'(q_a.pop_front());
            end
            if (rvalid_b) begin
                if (q_b.size() == 0) begin
                    check("b_spurious_rvalid", 64'(rvalid_b), 64'(0));
                end else begin
                    eb = q_b.pop_front();
                    check("b_rdata", 64'(rdata_b), 64'(eb.data));
                    check("b_latency_cycle", 64'(cyc), 64'(eb.due));
`ifdef SDPRAM_COLLISION_FLAG_EN
                    check("b_collision", 64'(coll_b), 64'(eb.coll));
`endif
                end
            end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
                check("b_missing_rvalid", 64'(rvalid_b), 64'(1));
                void'(q_b.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              we   wae  wa    wd     be   re   rae  ra    exp_rf    exp_wf    coll
        vecs.push_back(mk(1'b1,1'b1,4'd0, 8'h11,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd1, 8'h22,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b1,3'd0,16'h2211,16'h2211,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd0, 8'h99,1'b1,1'b1,1'b1,3'd0,16'h2211,16'h2299,1'b1));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b1,3'd0,16'h2299,16'h2299,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd2, 8'h33,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b1,1'b0,4'd5, 8'h44,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd3, 8'h55,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b1,3'd1,16'h5544,16'h5544,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd3, 8'h66,1'b0,1'b1,1'b1,3'd1,16'h5544,16'h5544,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b0,3'd6,16'h5544,16'h5544,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd2, 8'h77,1'b1,1'b1,1'b0,3'd6,16'h5544,16'h5577,1'b1));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b0,3'd6,16'h5577,16'h5577,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd14,8'hAA,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd15,8'hBB,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b1,3'd7,16'hBBAA,16'hBBAA,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd6, 8'hC6,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'd7, 8'hC7,1'b1,1'b0,1'b0,3'd0,16'h0000,16'h0000,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b1,3'd3,16'hC7C6,16'hC7C6,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b0,3'd0,16'hC7C6,16'hC7C6,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b0,3'd0,16'hC7C6,16'hC7C6,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b0,3'd0,16'hC7C6,16'hC7C6,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b1,3'd0,16'h2299,16'h2299,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'd0, 8'h00,1'b1,1'b1,1'b1,3'd1,16'h5577,16'h5577,1'b0));

        // Power-on reset: every output must be cleared.
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata_a", 64'(rdata_a), 64'(0));
        check("reset_rvalid_a", 64'(rvalid_a), 64'(0));
        check("reset_rdata_b", 64'(rdata_b), 64'(0));
        check("reset_rvalid_b", 64'(rvalid_b), 64'(0));
        check("reset_rdata_c", 64'(rdata_c), 64'(0));
        check("reset_rvalid_c", 64'(rvalid_c), 64'(0));
        check("reset_rdata_d", 64'(rdata_d), 64'(0));
        check("reset_rvalid_d", 64'(rvalid_d), 64'(0));
`ifdef SDPRAM_COLLISION_FLAG_EN
        check("reset_collision_a", 64'(coll_a), 64'(0));
        check("reset_collision_b", 64'(coll_b), 64'(0));
`endif
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        idle(2);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end
        idle(4);
        check("a_queue_drained", 64'(q_a.size()), 64'(0));
        check("b_queue_drained", 64'(q_b.size()), 64'(0));

        // Reset while reads are in flight: results dropped, memory untouched.
        mon_en = 1'b0;
        we = 0; re = 1; raddren = 1; raddr = 3'd0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_rdata_a", 64'(rdata_a), 64'(0));
        check("midreset_rvalid_a", 64'(rvalid_a), 64'(0));
        check("midreset_rdata_b", 64'(rdata_b), 64'(0));
        check("midreset_rvalid_b", 64'(rvalid_b), 64'(0));
        we = 1; waddren = 1; waddr = 4'd0; wdata = 8'hEE; byteen = 1; re = 1;
        repeat (2) @(posedge clk);
        #1;
        check("inreset_rvalid_a", 64'(rvalid_a), 64'(0));
        check("inreset_rvalid_b", 64'(rvalid_b), 64'(0));
        we = 0; re = 0; waddren = 0; raddren = 0;
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        idle(3);
        apply(mk(1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,1'b1,3'd0,16'h2299,16'h2299,1'b0));
        apply(mk(1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,1'b1,3'd1,16'h5577,16'h5577,1'b0));
        idle(4);
        check("a_queue_drained_post_reset", 64'(q_a.size()), 64'(0));
        check("b_queue_drained_post_reset", 64'(q_b.size()), 64'(0));

        // Reverse ratio: 16-bit writes, 8-bit reads.
        we_c = 1; waddren_c = 1; waddr_c = 3'd2; wdata_c = 16'hA5C3; byteen_c = 2'b11;
        @(posedge clk); #1;
        we_c = 0; re_c = 1; raddren_c = 1; raddr_c = 4'd4;
        @(posedge clk); #1;
        check("c_rvalid_lo", 64'(rvalid_c), 64'(1));
        check("c_rdata_lo", 64'(rdata_c), 64'(8'hC3));
        raddr_c = 4'd5;
        @(posedge clk); #1;
        check("c_rdata_hi", 64'(rdata_c), 64'(8'hA5));
        re_c = 0; we_c = 1; waddr_c = 3'd2; wdata_c = 16'h1234; byteen_c = 2'b10;
        @(posedge clk); #1;
        check("c_rvalid_idle", 64'(rvalid_c), 64'(0));
        check("c_rdata_hold", 64'(rdata_c), 64'(8'hA5));
        we_c = 0; re_c = 1; raddr_c = 4'd5;
        @(posedge clk); #1;
        check("c_partial_hi", 64'(rdata_c), 64'(8'h12));
        raddr_c = 4'd4;
        @(posedge clk); #1;
        check("c_partial_lo", 64'(rdata_c), 64'(8'hC3));
        re_c = 0;

        // Byte enables on a 32/32 instance.
        we_d = 1; waddren_d = 1; waddr_d = 2'd0; wdata_d = 32'h0000_0000; byteen_d = 4'b1111;
        @(posedge clk); #1;
        wdata_d = 32'hFFFF_FFFF; byteen_d = 4'b0101;
        @(posedge clk); #1;
        we_d = 0; re_d = 1; raddren_d = 1; raddr_d = 2'd0;
        @(posedge clk); #1;
        check("d_rvalid", 64'(rvalid_d), 64'(1));
        check("d_byteen_rdata", 64'(rdata_d), 64'(32'h00FF_00FF));
        re_d = 0;
        @(posedge clk); #1;
        check("d_rvalid_drop", 64'(rvalid_d), 64'(0));

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/efx_mixed_width_sdpram.md
Name: efx_mixed_width_sdpram

Overview:
- Single-clock simple dual-port block-RAM wrapper with independent write and read data widths (power-of-2 ratio in either direction).
- Per-byte write enables, read/write address-enable latches, selectable read-during-write collision mode, optional output register, and a read-valid pipeline.
- Successor to the fixed 8-in/16-out SDP wrapper; used as the generic buffer primitive for width-converting data paths in the Efinix designs.

Parameters:
- WR_DATA_WIDTH, 8, write port width; power of 2, 1..64.
- RD_DATA_WIDTH, 16, read port width; power of 2, 1..64.
- WR_ADDR_WIDTH, 4, write address width; write depth = 2**WR_ADDR_WIDTH words.
- BYTE_WIDTH, 8, byte-enable granularity; BYTEEN_WIDTH (localparam) = max(1, WR_DATA_WIDTH/BYTE_WIDTH).
- WRITE_MODE, "READ_FIRST", collision mode, "READ_FIRST" or "WRITE_FIRST".
- OUTPUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- RD_ADDR_WIDTH (localparam): total bits = WR_DATA_WIDTH*2**WR_ADDR_WIDTH; RD_ADDR_WIDTH = log2(total bits / RD_DATA_WIDTH).

Ports:
- clk, in, 1, single clock for both ports, rising edge.
- reset, in, 1, asynchronous, active-high.
- we, in, 1, write strobe.
- waddren, in, 1, 1 = capture waddr this cycle; 0 = reuse last latched write address.
- waddr, in, WR_ADDR_WIDTH, write word address.
- wdata, in, WR_DATA_WIDTH, write data.
- byteen, in, BYTEEN_WIDTH, per-byte write enable; bit i gates wdata[i*BYTE_WIDTH +: BYTE_WIDTH].
- re, in, 1, read strobe.
- raddren, in, 1, 1 = capture raddr this cycle; 0 = reuse last latched read address.
- raddr, in, RD_ADDR_WIDTH, read word address.
- rdata, out, RD_DATA_WIDTH, read data.
- rvalid, out, 1, rdata carries the result of a read.

Behaviour:
- Clock and reset: clk, single clock; reset, asynchronous, active-high.
- Storage:
  - Array of total bits, indexed in the narrower unit; RATIO = wide width / narrow width.
  - Narrow address k maps to lane (k % RATIO) of wide word (k / RATIO); lane 0 occupies the LSBs.
- Effective address:
  - eff_waddr = waddren ? waddr : wlatch; wlatch <= waddr when waddren=1.
  - Read side identical (eff_raddr, rlatch).
  - Both latches reset to 0.
- Write: at posedge with we=1, bytes with byteen=1 are written at eff_waddr; bytes with byteen=0 are unchanged.
- Read:
  - At posedge with re=1, the word at eff_raddr is loaded into the read stage.
  - OUTPUT_REG=0: rdata and rvalid update on that edge (latency 1).
  - OUTPUT_REG=1: one further register (latency 2).
  - When re=0: rdata holds its last value; rvalid deasserts at the corresponding latency.
- Collision (same edge; write and read cover overlapping bits):
  - READ_FIRST: returns pre-write contents.
  - WRITE_FIRST: returns new data for enabled overlapping bytes and old data elsewhere.
  - Non-overlapping lanes always return stored data.
- Reset:
  - rdata=0, rvalid=0, all pipeline stages and address latches = 0.
  - Memory contents are not cleared.
  - we and re are ignored while reset=1.
  - Reset mid-read drops in-flight results; no rvalid pulse is generated for them.
- Addresses wrap naturally at the port width; no out-of-range condition exists.
- Back-to-back reads every cycle give one rvalid per read, in order, with no bubbles.

Optional Feature:
- SDPRAM_COLLISION_FLAG_EN defined:
  - Adds output port collision (1 bit, reset 0).
  - Asserted aligned with rvalid for a read that overlapped a same-edge write on any enabled byte; otherwise 0.
- Not defined: port absent, no collision logic synthesised.

Test Plan:
- Defaults (8 in / 16 out): write 0x11,0x22 at waddr 0,1 with byteen=1, then re raddr=0 -> rdata=0x2211, rvalid=1 one cycle after the re edge.
- Reverse ratio (WR 16, RD 8): write 0xA5C3 to waddr 2 -> raddr 4 reads 0xC3, raddr 5 reads 0xA5.
- Byte enables (WR 32, RD 32, byteen=4'b0101): write 0xFFFFFFFF over 0x00000000 -> readback 0x00FF00FF.
- Collision, defaults, cell 0 holding 0x2211: same-edge write 0x99 to waddr 0 and read raddr 0:
  - READ_FIRST -> 0x2211.
  - WRITE_FIRST -> 0x2299.
  - With macro -> collision=1.
- OUTPUT_REG=1, raddren=0 after latching raddr=3: four consecutive reads -> four reads of word 3, rvalid high for 4 cycles starting 2 cycles after first re.
- Reset asserted while a read is in flight -> rdata=0, rvalid=0 immediately; after release, earlier written data reads back intact.
